// File: rtl/output_port_arbiter.sv
// Round-robin allocator for one router output port: grants one input whose
// FIFO head is a header flit and holds the grant until that packet's tail pops.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module output_port_arbiter #(
    parameter int NUM_IN = 3,
    parameter int PTR_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     req,
    input  logic [NUM_IN-1:0]     empty_in,
    input  logic [3*NUM_IN-1:0]   flit_type_in,
    input  logic                  out_ready,
    output logic [NUM_IN-1:0]     grant,
    output logic [NUM_IN-1:0]     rd_en,
    output logic                  valid_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_IN-1:0]   grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic [NUM_IN-1:0]   eligible_s;
    logic [NUM_IN-1:0]   sel_oh_s;
    logic                found_s;
    logic [PTR_W-1:0]    g_idx_s;
    logic                xfer_s;
    logic                is_tail_s;

    // Per-input eligibility: requesting, non-empty, and a header at the head.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            eligible_s[i] = req[i] & ~empty_in[i] & (flit_type_in[3*i +: 3] == `HEADER);
        end
    end

    // Round-robin scan starting just after the last served input.
    always_comb begin
        int idx;
        found_s  = 1'b0;
        sel_oh_s = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end else begin
                idx = idx;
            end
            if (!found_s && eligible_s[idx]) begin
                found_s       = 1'b1;
                sel_oh_s[idx] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Granted index and head-flit decode of the owning input (grant is one-hot).
    always_comb begin
        g_idx_s   = '0;
        is_tail_s = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) begin
                g_idx_s   = PTR_W'(i);
                is_tail_s = (flit_type_in[3*i +: 3] == `TAIL);
            end else begin
                g_idx_s   = g_idx_s;
            end
        end
    end

    // A flit moves whenever the owner has data and downstream can take it.
    always_comb begin
        if (state_q == ST_LOCKED) begin
            xfer_s = (|(grant_q & ~empty_in)) & out_ready;
        end else begin
            xfer_s = 1'b0;
        end
    end

    assign rd_en     = grant_q & {NUM_IN{xfer_s}};
    assign valid_out = xfer_s;
    assign grant     = grant_q;
    assign busy      = busy_q;

    // Next-state logic; req is deliberately ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d = sel_oh_s;
                    busy_d  = 1'b1;
                    state_d = ST_LOCKED;
                end else begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && is_tail_s) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = g_idx_s;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            // Dead cycle while upstream route bits still reflect the old packet.
            ST_RELEASE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; pointer resets so input 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= PTR_W'(NUM_IN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
